// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally at the current PC, and loads the IF/ID pipeline register.
//
// Each rising edge performs exactly one action, in this priority order:
//   reset > redirect (branch_taken) > ID hold > IF hold > normal advance
//
// Redirects and IF holds write a bubble (NOP_INSTR, pc4 = 0, valid = 0)
// into IF/ID and bump a saturating bubble counter. An ID hold freezes
// everything, because the instruction already in IF/ID must be replayed.
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0020,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFstall,
    input  logic        IDstall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_pc4,
    output logic        IFID_valid,
    output logic [15:0] bubble_cnt
);

    // One-hot-free encoding of the single action taken on the next edge.
    typedef enum logic [2:0] {
        ACT_RESET    = 3'd0,
        ACT_REDIRECT = 3'd1,
        ACT_ID_HOLD  = 3'd2,
        ACT_IF_HOLD  = 3'd3,
        ACT_ADVANCE  = 3'd4
    } fetch_act_t;

    // Architectural state
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;
    logic [15:0] bubble_cnt_r;

    // Combinational next-state
    fetch_act_t  act_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_next_s;
    logic [31:0] pc4_next_s;
    logic        valid_next_s;
    logic [15:0] bubble_cnt_next_s;
    logic        bubble_s;
    logic        cnt_sat_s;

    // PC+4 wraps modulo 2^32; no carry out is kept on purpose.
    assign pc_plus4_s = pc_r + 32'd4;
    assign cnt_sat_s  = (bubble_cnt_r == 16'hFFFF);

    // Resolve which single action this edge performs, honouring priority.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (reset) begin
            act_s = ACT_RESET;
        end else if (branch_taken) begin
            act_s = ACT_REDIRECT;
        end else if (IDstall) begin
            act_s = ACT_ID_HOLD;
        end else if (IFstall) begin
            act_s = ACT_IF_HOLD;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Compute next values of PC and IF/ID for the selected action.
    always_comb begin
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        pc4_next_s   = pc4_r;
        valid_next_s = valid_r;
        bubble_s     = 1'b0;
        case (act_s)
            ACT_RESET: begin
                pc_next_s    = RESET_PC;
                instr_next_s = NOP_INSTR;
                pc4_next_s   = 32'h0000_0000;
                valid_next_s = 1'b0;
                bubble_s     = 1'b0;
            end
            ACT_REDIRECT: begin
                // Target is taken verbatim; low bits are not masked.
                pc_next_s    = branch_target;
                instr_next_s = NOP_INSTR;
                pc4_next_s   = 32'h0000_0000;
                valid_next_s = 1'b0;
                bubble_s     = 1'b1;
            end
            ACT_ID_HOLD: begin
                pc_next_s    = pc_r;
                instr_next_s = instr_r;
                pc4_next_s   = pc4_r;
                valid_next_s = valid_r;
                bubble_s     = 1'b0;
            end
            ACT_IF_HOLD: begin
                // PC is held so the same address is fetched once the stall clears.
                pc_next_s    = pc_r;
                instr_next_s = NOP_INSTR;
                pc4_next_s   = 32'h0000_0000;
                valid_next_s = 1'b0;
                bubble_s     = 1'b1;
            end
            ACT_ADVANCE: begin
                pc_next_s    = pc_plus4_s;
                instr_next_s = imem_data;
                pc4_next_s   = pc_plus4_s;
                valid_next_s = 1'b1;
                bubble_s     = 1'b0;
            end
            default: begin
                // Unreachable encodings fall back to a safe bubble at reset PC.
                pc_next_s    = RESET_PC;
                instr_next_s = NOP_INSTR;
                pc4_next_s   = 32'h0000_0000;
                valid_next_s = 1'b0;
                bubble_s     = 1'b0;
            end
        endcase
    end

    // Saturating bubble counter next value; reset clear is handled in the register.
    always_comb begin
        bubble_cnt_next_s = bubble_cnt_r;
        if (bubble_s && !cnt_sat_s) begin
            bubble_cnt_next_s = bubble_cnt_r + 16'd1;
        end else begin
            bubble_cnt_next_s = bubble_cnt_r;
        end
    end

    // PC, IF/ID and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            pc4_r        <= 32'h0000_0000;
            valid_r      <= 1'b0;
            bubble_cnt_r <= 16'h0000;
        end else begin
            pc_r         <= pc_next_s;
            instr_r      <= instr_next_s;
            pc4_r        <= pc4_next_s;
            valid_r      <= valid_next_s;
            bubble_cnt_r <= bubble_cnt_next_s;
        end
    end

    // All outputs come straight from registers, so imem_addr only moves on edges.
    assign imem_addr  = pc_r;
    assign IFID_instr = instr_r;
    assign IFID_pc4   = pc4_r;
    assign IFID_valid = valid_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00400020, address of the first fetched instruction.
REQ-002 Parameter NOP_INSTR, default 32'h00000000, instruction word written into IF/ID on a bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IFstall  input  1  branch in ID or EX; fetch is held and a bubble is sent to ID.
REQ-006 IDstall  input  1  data hazard on the ID instruction; PC and IF/ID both hold.
REQ-007 branch_taken  input  1  branch resolved taken this cycle.
REQ-008 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-009 imem_data  input  32  instruction word at imem_addr, combinational read.
REQ-010 imem_addr  output  32  current PC, driven combinationally from the PC register.
REQ-011 IFID_instr  output  32  registered instruction presented to ID.
REQ-012 IFID_pc4  output  32  registered PC+4 of IFID_instr.
REQ-013 IFID_valid  output  1  1 = IFID_instr is a real instruction; 0 = bubble.
REQ-014 bubble_cnt  output  16  count of bubble cycles inserted since reset, saturating.

Function
REQ-015 Per-edge priority: reset > branch_taken > IDstall > IFstall > normal advance; exactly one action is taken each cycle.
REQ-016 Normal advance: PC <= PC+4; IFID_instr <= imem_data; IFID_pc4 <= PC+4; IFID_valid <= 1.
REQ-017 Redirect (branch_taken=1): PC <= branch_target; IFID_instr <= NOP_INSTR; IFID_valid <= 0; IFID_pc4 <= 0; bubble_cnt increments. This applies regardless of IDstall/IFstall.
REQ-018 ID hold (IDstall=1, branch_taken=0): PC and all IFID_* registers keep their values; bubble_cnt unchanged.
REQ-019 IF hold (IFstall=1, IDstall=0, branch_taken=0): PC holds; IFID_instr <= NOP_INSTR; IFID_valid <= 0; IFID_pc4 <= 0; bubble_cnt increments.
REQ-020 PC+4 is 32-bit modulo: 32'hFFFFFFFC advances to 32'h00000000 with no flag.
REQ-021 branch_target is loaded unmodified; the low two bits are not masked.
REQ-022 bubble_cnt saturates at 16'hFFFF and holds there until reset.
REQ-023 Latency: imem_data sampled at edge N appears on IFID_instr immediately after edge N (one cycle from imem_addr to ID).
REQ-024 imem_addr changes only at clock edges, never from input changes within a cycle.
REQ-025 A stall held for K consecutive cycles produces K holds with no PC drift, and the instruction at the held PC is fetched on the first non-stall edge.

Reset
REQ-026 While reset=1 at an edge: PC <= RESET_PC; IFID_instr <= NOP_INSTR; IFID_pc4 <= 0; IFID_valid <= 0; bubble_cnt <= 0.
REQ-027 Reset overrides all stall and branch inputs, including asserted mid-stall or mid-redirect.
REQ-028 The first edge after reset deasserts with no stall fetches from RESET_PC.

Verification
REQ-029 Reset, then 3 free-running cycles with imem_data = A,B,C -> imem_addr 0x00400020, 0x00400024, 0x00400028, 0x0040002C; IFID_instr = A,B,C, IFID_pc4 = 0x00400024.., IFID_valid = 1.
REQ-030 IFstall=1 for 2 cycles at PC 0x00400028 -> PC holds, 2 bubbles (valid=0, instr=0), bubble_cnt=2; next edge fetches from 0x00400028.
REQ-031 IDstall=1 for 3 cycles with IFID_instr=B -> IFID_instr, IFID_pc4 and PC unchanged for 3 cycles, bubble_cnt unchanged.
REQ-032 branch_taken=1, branch_target=0x00400100, together with IDstall=1 and IFstall=1 -> next PC 0x00400100, IFID_valid=0, bubble_cnt+1.
REQ-033 PC forced to 0xFFFFFFFC via branch_target, one normal cycle -> IFID_pc4=0x00000000, imem_addr=0x00000000.
REQ-034 reset asserted during an IFstall sequence with bubble_cnt=16'hFFFF -> all outputs take reset values at that edge; bubble_cnt=0.
